// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, refresh FSM states and default timing.
package sdram_pkg;

  // {CS#, RAS#, CAS#, WE#}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_AR  = 4'b0001;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  localparam int DEF_REF_INTERVAL = 780;
  localparam int DEF_TRP_CYC      = 2;
  localparam int DEF_TRFC_CYC     = 7;
  localparam int DEF_MAX_DEBT     = 8;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_TRP, ST_AR, ST_TRFC, ST_END
  } ar_state_t;

endpackage

// File: rtl/sdram_aref_timer.sv
// Refresh interval counter and saturating refresh-debt accumulator.
module sdram_aref_timer #(
  parameter int REF_INTERVAL = 780,
  parameter int MAX_DEBT     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_end,
  input  logic       issue,
  output logic [3:0] debt,
  output logic [3:0] debt_next,
  output logic       urgent,
  output logic       ovf
);

  localparam int              CW       = $clog2(REF_INTERVAL);
  localparam logic [CW-1:0]   CNT_LAST = CW'(REF_INTERVAL - 1);
  localparam logic [3:0]      DMAX     = 4'(MAX_DEBT);

  logic [CW-1:0] cnt;
  logic          tick;
  logic          sat;

  assign tick = init_end && (cnt == CNT_LAST);
  // A tick with nowhere to go is lost; remember it for the error flag.
  assign sat  = tick && !issue && (debt == DMAX);

  always_comb begin
    debt_next = debt;
    if (tick && !issue && (debt != DMAX))
      debt_next = debt + 4'd1;
    else if (issue && !tick && (debt != 4'd0))
      debt_next = debt - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      debt   <= 4'd0;
      urgent <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      cnt    <= (!init_end || cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      debt   <= debt_next;
      urgent <= (debt_next == DMAX);
      ovf    <= ovf | sat;
    end
  end

endmodule

// File: rtl/sdram_aref_pp.sv
// SDRAM auto-refresh engine: one PRECHARGE-ALL then AUTO REFRESH until the
// accumulated debt (including ticks arriving mid-burst) is drained.
module sdram_aref_pp
  import sdram_pkg::*;
#(
  parameter int REF_INTERVAL = DEF_REF_INTERVAL,
  parameter int TRP_CYC      = DEF_TRP_CYC,
  parameter int TRFC_CYC     = DEF_TRFC_CYC,
  parameter int MAX_DEBT     = DEF_MAX_DEBT,
  parameter int ADDR_W       = 13,
  parameter int BANK_W       = 2
) (
  input  logic              ar_clk,
  input  logic              ar_rst_n,
  input  logic              init_end,
  input  logic              ar_en,
  output logic              ar_req,
  output logic              ar_urgent,
  output logic              ar_busy,
  output logic              ar_end,
  output logic              ar_ovf,
  output logic [3:0]        ar_cmd,
  output logic [BANK_W-1:0] ar_bank,
  output logic [ADDR_W-1:0] ar_addr,
  output logic [3:0]        ar_debt
);

  localparam int            WMAX      = (TRP_CYC > TRFC_CYC) ? TRP_CYC : TRFC_CYC;
  localparam int            WW        = $clog2(WMAX + 1);
  localparam logic [WW-1:0] TRP_LAST  = WW'(TRP_CYC - 1);
  localparam logic [WW-1:0] TRFC_LAST = WW'(TRFC_CYC - 1);

  ar_state_t     state, state_next;
  logic [WW-1:0] wcnt;
  logic [3:0]    debt, debt_next;

  sdram_aref_timer #(
    .REF_INTERVAL(REF_INTERVAL),
    .MAX_DEBT    (MAX_DEBT)
  ) u_timer (
    .clk      (ar_clk),
    .rst_n    (ar_rst_n),
    .init_end (init_end),
    .issue    (state == ST_AR),
    .debt     (debt),
    .debt_next(debt_next),
    .urgent   (ar_urgent),
    .ovf      (ar_ovf)
  );

  // All ones: A10 high makes the PRECHARGE hit every bank.
  assign ar_bank = '1;
  assign ar_addr = '1;
  assign ar_debt = debt;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (init_end && ar_en && debt != 4'd0) state_next = ST_PRE;
      ST_PRE:  state_next = ST_TRP;
      ST_TRP:  if (wcnt == TRP_LAST) state_next = ST_AR;
      ST_AR:   state_next = ST_TRFC;
      ST_TRFC: if (wcnt == TRFC_LAST) state_next = (debt != 4'd0) ? ST_AR : ST_END;
      ST_END:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ar_clk or negedge ar_rst_n) begin
    if (!ar_rst_n) begin
      state   <= ST_IDLE;
      wcnt    <= '0;
      ar_cmd  <= CMD_NOP;
      ar_req  <= 1'b0;
      ar_busy <= 1'b0;
      ar_end  <= 1'b0;
    end else begin
      state   <= state_next;
      wcnt    <= (state_next == state && (state == ST_TRP || state == ST_TRFC)) ?
                 wcnt + 1'b1 : '0;
      ar_cmd  <= (state == ST_PRE) ? CMD_PRE : (state == ST_AR) ? CMD_AR : CMD_NOP;
      ar_req  <= (state_next == ST_IDLE) && (debt_next != 4'd0);
      ar_busy <= (state_next != ST_IDLE);
      ar_end  <= (state == ST_END);
    end
  end

endmodule

// File: tb/tb_sdram_aref_pp.sv
// Randomised bench: a timing-level reference model predicts command/end events
// into a scoreboard queue and per-cycle status levels; a monitor compares.
module tb_sdram_aref_pp;
  import sdram_pkg::*;

  localparam int RI = 20, TRP = 2, TRFC = 7, MD = 4, AW = 13, BW = 2;

  logic          clk = 1'b0, rst_n = 1'b0, init_end = 1'b0, ar_en = 1'b0;
  logic          ar_req, ar_urgent, ar_busy, ar_end, ar_ovf;
  logic [3:0]    ar_cmd, ar_debt;
  logic [BW-1:0] ar_bank;
  logic [AW-1:0] ar_addr;

  sdram_aref_pp #(
    .REF_INTERVAL(RI), .TRP_CYC(TRP), .TRFC_CYC(TRFC), .MAX_DEBT(MD),
    .ADDR_W(AW), .BANK_W(BW)
  ) dut (
    .ar_clk(clk), .ar_rst_n(rst_n), .init_end(init_end), .ar_en(ar_en),
    .ar_req(ar_req), .ar_urgent(ar_urgent), .ar_busy(ar_busy), .ar_end(ar_end),
    .ar_ovf(ar_ovf), .ar_cmd(ar_cmd), .ar_bank(ar_bank), .ar_addr(ar_addr),
    .ar_debt(ar_debt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] cmd;
    bit         endp;
  } ev_t;

  typedef struct packed {
    logic       req, urg, busy, ovf;
    logic [3:0] debt;
  } lvl_t;

  ev_t  evq[$];
  int   flush_to = 0, rd = 0;
  lvl_t exp_l = '0, act_l;
  int   cyc = 0;
  int   checks = 0, errors = 0, tmo = 0;
  bit   done = 1'b0, fin = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model, in terms of timing offsets from the grant.
  int m_icnt = 0, m_debt = 0, m_bt = 0, m_ar_at = 0, m_end_at = 0;
  bit m_inb = 1'b0, m_ovf = 1'b0, m_tick, m_issue;

  task automatic push_ev(input int c, input logic [3:0] cmd, input bit endp);
    ev_t e;
    e.cyc = c; e.cmd = cmd; e.endp = endp;
    evq.push_back(e);
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_icnt = 0; m_debt = 0; m_inb = 1'b0; m_ovf = 1'b0; m_bt = 0;
      flush_to = evq.size();
      exp_l = '0;
    end else begin
      m_tick  = init_end && (m_icnt == RI - 1);
      m_issue = m_inb && (m_bt == m_ar_at);
      if (m_inb && m_bt == 0)        push_ev(cyc + 1, CMD_PRE, 1'b0);
      if (m_issue)                   push_ev(cyc + 1, CMD_AR, 1'b0);
      if (m_inb && m_bt == m_end_at) push_ev(cyc + 1, CMD_NOP, 1'b1);
      if (m_inb) begin
        if (m_bt == m_end_at) m_inb = 1'b0;
        else begin
          if (m_bt == m_ar_at + TRFC) begin
            if (m_debt != 0) m_ar_at = m_bt + 1;
            else             m_end_at = m_bt + 1;
          end
          m_bt++;
        end
      end else if (init_end && ar_en && m_debt != 0) begin
        m_inb = 1'b1; m_bt = 0; m_ar_at = TRP + 1; m_end_at = 1 << 30;
      end
      if (m_tick && !m_issue) begin
        if (m_debt == MD) m_ovf = 1'b1;
        else              m_debt++;
      end else if (m_issue && !m_tick) m_debt--;
      m_icnt = init_end ? (m_icnt + 1) % RI : 0;
      exp_l.req  = !m_inb && (m_debt != 0);
      exp_l.urg  = (m_debt == MD);
      exp_l.busy = m_inb;
      exp_l.ovf  = m_ovf;
      exp_l.debt = 4'(m_debt);
    end
  end

  // Monitor / scoreboard.
  initial forever begin
    @(negedge clk);
    if (rd < flush_to) rd = flush_to;
    act_l = {ar_req, ar_urgent, ar_busy, ar_ovf, ar_debt};
    checks++;
    if (act_l !== exp_l) begin
      errors++;
      $display("FAIL levels cyc=%0d req/urg/busy/ovf/debt got %b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
               cyc, act_l.req, act_l.urg, act_l.busy, act_l.ovf, act_l.debt,
               exp_l.req, exp_l.urg, exp_l.busy, exp_l.ovf, exp_l.debt);
    end
    checks++;
    if (ar_bank !== {BW{1'b1}} || ar_addr !== {AW{1'b1}}) begin
      errors++;
      $display("FAIL bank_addr cyc=%0d got %b/%h want all ones", cyc, ar_bank, ar_addr);
    end
    while (rd < evq.size() && evq[rd].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL missed_event cyc=%0d got nothing want cmd=%b end=%0d at cyc %0d",
               cyc, evq[rd].cmd, evq[rd].endp, evq[rd].cyc);
      rd++;
    end
    if (ar_cmd !== CMD_NOP || ar_end !== 1'b0) begin
      checks++;
      if (rd >= evq.size()) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d got cmd=%b end=%b want none", cyc, ar_cmd, ar_end);
      end else begin
        if (evq[rd].cyc != cyc || evq[rd].cmd !== ar_cmd || evq[rd].endp != ar_end) begin
          errors++;
          $display("FAIL event cyc=%0d got cmd=%b end=%b want cmd=%b end=%0d at cyc %0d",
                   cyc, ar_cmd, ar_end, evq[rd].cmd, evq[rd].endp, evq[rd].cyc);
        end
        rd++;
      end
    end
    if (done && !fin) begin
      checks++;
      if (rd != evq.size() || tmo != 0) begin
        errors++;
        $display("FAIL drain got %0d pending events and %0d timeouts want 0 and 0",
                 evq.size() - rd, tmo);
      end
      fin = 1'b1;
    end
  end

  // en_mode: 0/1 fixed grant level, 2 random grant each cycle.
  task automatic cycles(input int n, input bit ie, input int en_mode);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      init_end = ie;
      ar_en = (en_mode == 2) ? 1'($urandom_range(0, 1)) : en_mode[0];
    end
  endtask

  task automatic pulse_reset(input int n);
    @(negedge clk); #1;
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    // no ticks before init completes
    cycles(100, 1'b0, 2);
    // granted as soon as a tick arrives
    cycles(60, 1'b1, 1);
    // postponed debt of 3, then one burst
    pulse_reset(2);
    cycles(70 + $urandom_range(0, 5), 1'b1, 0);
    cycles(40, 1'b1, 1);
    // saturate, overflow, then drain
    cycles(100, 1'b1, 0);
    cycles(60, 1'b1, 1);
    // tick landing inside TRFC of a single-refresh burst
    repeat (3) begin
      cycles(1, 1'b1, 0);
      for (int i = 0; i < 2 * RI && !ar_req; i++) cycles(1, 1'b1, 0);
      if (!ar_req) tmo++;
      cycles($urandom_range(8, 13), 1'b1, 0);
      cycles(30, 1'b1, 1);
    end
    // reset during TRP
    for (int i = 0; i < 3 * RI && !ar_busy; i++) cycles(1, 1'b1, 1);
    if (!ar_busy) tmo++;
    pulse_reset(3);
    cycles(50, 1'b1, 1);
    // random mix, including init_end dropping mid-burst
    repeat (30) cycles($urandom_range(5, 40), ($urandom_range(0, 7) != 0), 2);
    pulse_reset(1);
    repeat (10) cycles($urandom_range(5, 40), ($urandom_range(0, 7) != 0), 2);
    cycles(40, 1'b1, 1);
    done = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
